// File: rtl/sa_fifo_ctrl_19x4_if.sv
// Push/pop handshake bundle for the 19x4 RAM-backed FIFO controller.
// The slave side is the FIFO itself; the master side is producer plus consumer.
interface sa_fifo_ctrl_19x4_if;
    logic       wr_pvld;
    logic       wr_prdy;
    logic [3:0] wr_pd;
    logic       rd_pvld;
    logic       rd_prdy;
    logic [3:0] rd_pd;
    logic [4:0] fifo_cnt;

    modport master (
        output wr_pvld, wr_pd, rd_prdy,
        input  wr_prdy, rd_pvld, rd_pd, fifo_cnt
    );

    modport slave (
        input  wr_pvld, wr_pd, rd_prdy,
        output wr_prdy, rd_pvld, rd_pd, fifo_cnt
    );
endinterface

// File: rtl/sa_fifo_ctrl_19x4.sv
// Valid/ready FIFO controller around a 19x4 two-stage-read RAM (read-address
// register s1, output register s2 with bypass mux); 20 entries total.
module sa_fifo_ctrl_19x4 (
    input  logic                     clk,
    input  logic                     rstn,
    sa_fifo_ctrl_19x4_if.slave       fifo,
    output logic [4:0]               ram_ra,
    output logic                     ram_re,
    output logic                     ram_ore,
    output logic [4:0]               ram_wa,
    output logic                     ram_we,
    output logic [3:0]               ram_di,
    output logic                     ram_byp_sel,
    output logic [3:0]               ram_dbyp,
    input  logic [3:0]               ram_dout
);
    localparam logic [4:0] RAM_DEPTH = 5'd19;
    localparam logic [4:0] PTR_LAST  = 5'd18;

    logic [4:0] r_wr_ptr;
    logic [4:0] r_rd_ptr;
    logic [4:0] r_ram_cnt;
    logic       r_s1_vld;
    logic       r_s2_vld;

    logic       w_wr_prdy;
    logic       w_push;
    logic       w_s2_free;
    logic       w_byp;
    logic       w_we;
    logic       w_s1_adv;
    logic       w_issue;
    logic       w_ore;

    function automatic logic [4:0] ptr_inc(input logic [4:0] p);
        return (p == PTR_LAST) ? 5'd0 : p + 5'd1;
    endfunction

    // Every enable is qualified by rstn so the RAM sees no activity during reset.
    always_comb begin
        w_wr_prdy = (r_ram_cnt < RAM_DEPTH);
        w_push    = rstn & fifo.wr_pvld & w_wr_prdy;
        w_s2_free = ~r_s2_vld | fifo.rd_prdy;
        w_byp     = w_push & (r_ram_cnt == 5'd0) & w_s2_free;
        w_we      = w_push & ~w_byp;
        w_s1_adv  = rstn & r_s1_vld & w_s2_free;
        // s1 entries stay in r_ram_cnt, so only the remainder is issuable.
        w_issue   = rstn & (r_ram_cnt > {4'd0, r_s1_vld}) & (~r_s1_vld | w_s1_adv);
        w_ore     = w_byp | w_s1_adv;
    end

    always_comb begin
        ram_we      = w_we;
        ram_wa      = w_we ? r_wr_ptr : 5'd0;
        ram_di      = w_we ? fifo.wr_pd : 4'd0;
        ram_re      = w_issue;
        ram_ra      = w_issue ? r_rd_ptr : 5'd0;
        ram_ore     = w_ore;
        ram_byp_sel = w_byp;
        ram_dbyp    = w_byp ? fifo.wr_pd : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr  <= 5'd0;
            r_rd_ptr  <= 5'd0;
            r_ram_cnt <= 5'd0;
            r_s1_vld  <= 1'b0;
            r_s2_vld  <= 1'b0;
        end else begin
            if (w_we)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_issue)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_we, w_s1_adv})
                2'b10:   r_ram_cnt <= r_ram_cnt + 5'd1;
                2'b01:   r_ram_cnt <= r_ram_cnt - 5'd1;
                default: r_ram_cnt <= r_ram_cnt;
            endcase
            if (w_issue)
                r_s1_vld <= 1'b1;
            else if (w_s1_adv)
                r_s1_vld <= 1'b0;
            r_s2_vld <= (r_s2_vld & ~fifo.rd_prdy) | w_ore;
        end
    end

    assign fifo.wr_prdy  = w_wr_prdy;
    assign fifo.rd_pvld  = r_s2_vld;
    assign fifo.rd_pd    = ram_dout;
    assign fifo.fifo_cnt = r_ram_cnt + {4'd0, r_s2_vld};
endmodule

// File: tb/tb_sa_fifo_ctrl_19x4.sv
// Directed bench for sa_fifo_ctrl_19x4 with a behavioural two-stage RAM and
// a reference queue for pop data.
module tb_sa_fifo_ctrl_19x4;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    sa_fifo_ctrl_19x4_if bus ();

    logic [4:0] ram_ra;
    logic       ram_re;
    logic       ram_ore;
    logic [4:0] ram_wa;
    logic       ram_we;
    logic [3:0] ram_di;
    logic       ram_byp_sel;
    logic [3:0] ram_dbyp;
    logic [3:0] ram_dout;

    sa_fifo_ctrl_19x4 dut (
        .clk         (clk),
        .rstn        (rstn),
        .fifo        (bus),
        .ram_ra      (ram_ra),
        .ram_re      (ram_re),
        .ram_ore     (ram_ore),
        .ram_wa      (ram_wa),
        .ram_we      (ram_we),
        .ram_di      (ram_di),
        .ram_byp_sel (ram_byp_sel),
        .ram_dbyp    (ram_dbyp),
        .ram_dout    (ram_dout)
    );

    // Two-stage-read RAM: registered read address, output register with bypass.
    logic [3:0] mem [0:31];
    logic [4:0] ra_q = 5'd0;
    logic [3:0] dout_q = 4'd0;
    always @(posedge clk) begin
        if (ram_we)  mem[ram_wa] <= ram_di;
        if (ram_re)  ra_q <= ram_ra;
        if (ram_ore) dout_q <= ram_byp_sel ? ram_dbyp : mem[ra_q];
    end
    assign ram_dout = dout_q;

    int n_cmp = 0;
    int n_err = 0;
    int wraps = 0;
    logic [3:0] q [$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard the current cycle's handshakes, then advance one clock.
    task automatic tick();
        logic [3:0] exp_d;
        if (rstn) begin
            if (bus.rd_pvld && bus.rd_prdy) begin
                check_eq("pop_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    exp_d = q.pop_front();
                    $display("pop  data=0x%0h expect=0x%0h", bus.rd_pd, exp_d);
                    check_eq("pop_data", 32'(bus.rd_pd), 32'(exp_d));
                end
            end
            if (bus.wr_pvld && bus.wr_prdy) q.push_back(bus.wr_pd);
            if (ram_we) begin
                check_eq("wa_range", 32'(ram_wa < 5'd19), 32'd1);
                if (ram_wa == 5'd18) wraps++;
            end
            if (ram_re) check_eq("ra_range", 32'(ram_ra < 5'd19), 32'd1);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag, input int budget);
        int c;
        c = 0;
        bus.wr_pvld = 1'b0;
        bus.rd_prdy = 1'b1;
        while (q.size() != 0 && c < budget) begin
            #1;
            tick();
            c++;
        end
        check_eq(tag, 32'(q.size()), 32'd0);
        #1;
        check_eq({tag, "_cnt"}, 32'(bus.fifo_cnt), 32'd0);
    endtask

    initial begin
        int pushed;
        int cyc;
        bus.wr_pvld = 1'b0;
        bus.wr_pd   = 4'd0;
        bus.rd_prdy = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state
        check_eq("rst_we",  32'(ram_we),  32'd0);
        check_eq("rst_re",  32'(ram_re),  32'd0);
        check_eq("rst_ore", 32'(ram_ore), 32'd0);
        rstn = 1'b1;
        #1;
        check_eq("rst_prdy", 32'(bus.wr_prdy),  32'd1);
        check_eq("rst_pvld", 32'(bus.rd_pvld),  32'd0);
        check_eq("rst_cnt",  32'(bus.fifo_cnt), 32'd0);

        // Bypass
        bus.wr_pvld = 1'b1; bus.wr_pd = 4'hA; bus.rd_prdy = 1'b1;
        #1;
        check_eq("byp_we",   32'(ram_we),      32'd0);
        check_eq("byp_sel",  32'(ram_byp_sel), 32'd1);
        check_eq("byp_ore",  32'(ram_ore),     32'd1);
        check_eq("byp_dbyp", 32'(ram_dbyp),    32'hA);
        tick();
        bus.wr_pvld = 1'b0;
        #1;
        check_eq("byp_pvld", 32'(bus.rd_pvld),  32'd1);
        check_eq("byp_pd",   32'(bus.rd_pd),    32'hA);
        check_eq("byp_cnt1", 32'(bus.fifo_cnt), 32'd1);
        tick();
        check_eq("byp_cnt0", 32'(bus.fifo_cnt), 32'd0);
        check_eq("byp_pvld0", 32'(bus.rd_pvld), 32'd0);

        // Fill to 20
        bus.rd_prdy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.wr_pvld = 1'b1;
            bus.wr_pd   = 4'(i);
            #1;
            check_eq("fill_prdy", 32'(bus.wr_prdy), 32'd1);
            tick();
        end
        check_eq("full_cnt",  32'(bus.fifo_cnt), 32'd20);
        check_eq("full_prdy", 32'(bus.wr_prdy),  32'd0);
        bus.wr_pd = 4'h4;
        #1;
        check_eq("full_we",  32'(ram_we),  32'd0);
        check_eq("full_ore", 32'(ram_ore), 32'd0);
        tick();
        check_eq("full_cnt2", 32'(bus.fifo_cnt), 32'd20);
        bus.wr_pvld = 1'b0;

        // Drain in order, no bubbles
        bus.rd_prdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            check_eq("drain_pvld", 32'(bus.rd_pvld), 32'd1);
            if (i == 1) check_eq("drain_prdy", 32'(bus.wr_prdy), 32'd1);
            tick();
        end
        check_eq("drain_q",   32'(q.size()),     32'd0);
        check_eq("drain_cnt", 32'(bus.fifo_cnt), 32'd0);

        // Wrap-around with random pop ready
        wraps  = 0;
        pushed = 0;
        cyc    = 0;
        while (pushed < 66 && cyc < 400) begin
            bus.wr_pvld = 1'b1;
            bus.wr_pd   = pushed[3:0];
            bus.rd_prdy = (cyc < 4) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            if (bus.wr_prdy) pushed++;
            tick();
            cyc++;
        end
        check_eq("wrap_pushed", 32'(pushed), 32'd66);
        drain("wrap_drain", 200);
        check_eq("wrap_count", 32'(wraps >= 3), 32'd1);

        // Stall with s1 and s2 both occupied
        bus.rd_prdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.wr_pvld = 1'b1;
            bus.wr_pd   = 4'(i + 3);
            #1;
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            bus.wr_pvld = 1'b1;
            bus.wr_pd   = 4'(15 - i);
            #1;
            check_eq("stall_re",  32'(ram_re),  32'd0);
            check_eq("stall_ore", 32'(ram_ore), 32'd0);
            tick();
        end
        check_eq("stall_cnt", 32'(bus.fifo_cnt), 32'd15);
        drain("stall_drain", 100);

        // Reset mid-operation
        bus.rd_prdy = 1'b0;
        for (int i = 0; i < 7; i++) begin
            bus.wr_pvld = 1'b1;
            bus.wr_pd   = 4'(i + 9);
            #1;
            tick();
        end
        check_eq("mid_cnt7", 32'(bus.fifo_cnt), 32'd7);
        rstn = 1'b0;
        #1;
        check_eq("mid_rst_we",  32'(ram_we),  32'd0);
        check_eq("mid_rst_re",  32'(ram_re),  32'd0);
        check_eq("mid_rst_ore", 32'(ram_ore), 32'd0);
        tick();
        rstn = 1'b1;
        bus.wr_pvld = 1'b0;
        q.delete();
        #1;
        check_eq("mid_pvld", 32'(bus.rd_pvld),  32'd0);
        check_eq("mid_cnt",  32'(bus.fifo_cnt), 32'd0);
        check_eq("mid_prdy", 32'(bus.wr_prdy),  32'd1);
        bus.wr_pvld = 1'b1; bus.wr_pd = 4'h5; bus.rd_prdy = 1'b1;
        #1;
        check_eq("mid_byp_sel", 32'(ram_byp_sel), 32'd1);
        check_eq("mid_byp_we",  32'(ram_we),      32'd0);
        tick();
        bus.wr_pvld = 1'b0;
        #1;
        check_eq("mid_byp_pvld", 32'(bus.rd_pvld), 32'd1);
        check_eq("mid_byp_pd",   32'(bus.rd_pd),   32'h5);
        tick();
        check_eq("mid_end_cnt", 32'(bus.fifo_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
